// File: rtl/uvma_wfe_wu_mc_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uvma_wfe_wu_mc_chk_pkg                                          |
// | Purpose  : Shared types and helpers for the multi-channel WFE wake-up      |
// |            checker: per-channel FSM state, sticky error bundle and a       |
// |            saturating increment.                                           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package uvma_wfe_wu_mc_chk_pkg;

  typedef enum logic [1:0] {
    ST_AWAKE   = 2'd0,
    ST_SLEEP   = 2'd1,
    ST_WU_PEND = 2'd2
  } wfe_state_e;

  // Sticky protocol errors of one channel.
  typedef struct packed {
    logic timeout;
    logic drop;
    logic wake_nowu;
  } ch_err_t;

  // Increment that stops at lim; callers pass their all-ones value as lim
  // so counters of any width up to 32 bits saturate instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] lim);
    return (val >= lim) ? lim : val + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uvma_wfe_wu_ch_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uvma_wfe_wu_ch_chk                                              |
// | Purpose  : Single-channel WFE wake-up checker: AWAKE/SLEEP/WU_PEND FSM,    |
// |            wake latency counter, good-wake counter, sticky errors.         |
// | Ports    : clk, reset       - clock, synchronous active-high reset         |
// |            en_i             - 0 freezes all state                          |
// |            core_sleep_i     - core sleeping indication                     |
// |            wu_wfe_i         - wake-up request                              |
// |            err_o            - sticky error bundle                          |
// |            last_lat_o       - latency of most recent good wake             |
// |            wake_cnt_o       - saturating good-wake count                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uvma_wfe_wu_ch_chk
  import uvma_wfe_wu_mc_chk_pkg::*;
#(
  parameter int unsigned MAX_WU_LAT = 16,
  parameter int unsigned LAT_W      = 8,
  parameter int unsigned WU_LEVEL   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             core_sleep_i,
  input  logic             wu_wfe_i,
  output ch_err_t          err_o,
  output logic [LAT_W-1:0] last_lat_o,
  output logic [LAT_W-1:0] wake_cnt_o
);

  localparam logic [LAT_W-1:0] C_MAX  = LAT_W'(MAX_WU_LAT);
  localparam logic [LAT_W-1:0] C_ALL1 = '1;

  typedef struct packed {
    ch_err_t          err;
    logic [LAT_W-1:0] last_lat;
    logic [LAT_W-1:0] wake_cnt;
  } ch_status_t;

  wfe_state_e       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  ch_status_t       st_q, st_d;
  logic [LAT_W-1:0] lat_inc;
  logic [LAT_W-1:0] wake_cnt_inc;

  // lat_q counts completed sleeping cycles since the wake-up was accepted, so
  // the latency at the waking edge is lat_q + 1. Timeout fires first, so this
  // never wraps (2**LAT_W > MAX_WU_LAT).
  assign lat_inc      = lat_q + LAT_W'(1);
  assign wake_cnt_inc = LAT_W'(sat_inc(32'(st_q.wake_cnt), 32'(C_ALL1)));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    st_d    = st_q;
    if (en_i) begin
      unique case (state_q)
        ST_AWAKE: begin
          // A wake-up seen while awake is latched by the core: ignored.
          if (core_sleep_i) begin
            lat_d   = '0;
            state_d = wu_wfe_i ? ST_WU_PEND : ST_SLEEP;
          end
        end
        ST_SLEEP: begin
          if (wu_wfe_i) begin
            if (core_sleep_i) begin
              state_d = ST_WU_PEND;
              lat_d   = '0;
            end else begin
              // Request and wake on the same edge: good wake, latency 0.
              state_d       = ST_AWAKE;
              st_d.last_lat = '0;
              st_d.wake_cnt = wake_cnt_inc;
            end
          end else if (!core_sleep_i) begin
            state_d            = ST_AWAKE;
            st_d.err.wake_nowu = 1'b1;
          end
        end
        ST_WU_PEND: begin
          if (!core_sleep_i) begin
            state_d       = ST_AWAKE;
            st_d.last_lat = lat_inc;
            st_d.wake_cnt = wake_cnt_inc;
          end else begin
            if ((WU_LEVEL != 0) && !wu_wfe_i) begin
              st_d.err.drop = 1'b1;
            end
            if (lat_inc >= C_MAX) begin
              // Give up on this request; a fresh wake-up restarts measurement.
              st_d.err.timeout = 1'b1;
              state_d          = ST_SLEEP;
              lat_d            = '0;
            end else begin
              lat_d = lat_inc;
            end
          end
        end
        default: begin
          state_d = ST_AWAKE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_AWAKE;
      lat_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      st_q    <= st_d;
    end
  end

  assign err_o      = st_q.err;
  assign last_lat_o = st_q.last_lat;
  assign wake_cnt_o = st_q.wake_cnt;

endmodule
`default_nettype wire

// File: rtl/uvma_wfe_wu_mc_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uvma_wfe_wu_mc_chk                                              |
// | Purpose  : Multi-channel WFE wake-up checker; one independent channel      |
// |            checker per core, packed status outputs and registered OR of    |
// |            all sticky errors.                                              |
// | Ports    : clk, reset       - clock, synchronous active-high reset         |
// |            core_sleep_i     - per-channel core sleeping indication         |
// |            wu_wfe_i         - per-channel wake-up request                  |
// |            chk_en_i         - global enable, 0 freezes everything          |
// |            err_timeout_o    - sticky wake latency timeout                  |
// |            err_drop_o       - sticky wake-up dropped early (level mode)    |
// |            err_wake_nowu_o  - sticky wake without request                  |
// |            last_lat_o       - per-channel last good wake latency           |
// |            wake_cnt_o       - per-channel saturating good-wake count       |
// |            err_any_o        - registered OR of all sticky errors           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uvma_wfe_wu_mc_chk
  import uvma_wfe_wu_mc_chk_pkg::*;
#(
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned MAX_WU_LAT = 16,
  parameter int unsigned LAT_W      = 8,
  parameter int unsigned WU_LEVEL   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       core_sleep_i,
  input  logic [NUM_CH-1:0]       wu_wfe_i,
  input  logic                    chk_en_i,
  output logic [NUM_CH-1:0]       err_timeout_o,
  output logic [NUM_CH-1:0]       err_drop_o,
  output logic [NUM_CH-1:0]       err_wake_nowu_o,
  output logic [NUM_CH*LAT_W-1:0] last_lat_o,
  output logic [NUM_CH*LAT_W-1:0] wake_cnt_o,
  output logic                    err_any_o
);

  ch_err_t ch_err [NUM_CH];
  logic    err_any_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    uvma_wfe_wu_ch_chk #(
      .MAX_WU_LAT (MAX_WU_LAT),
      .LAT_W      (LAT_W),
      .WU_LEVEL   (WU_LEVEL)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .en_i         (chk_en_i),
      .core_sleep_i (core_sleep_i[g]),
      .wu_wfe_i     (wu_wfe_i[g]),
      .err_o        (ch_err[g]),
      .last_lat_o   (last_lat_o[g*LAT_W +: LAT_W]),
      .wake_cnt_o   (wake_cnt_o[g*LAT_W +: LAT_W])
    );

    assign err_timeout_o[g]   = ch_err[g].timeout;
    assign err_drop_o[g]      = ch_err[g].drop;
    assign err_wake_nowu_o[g] = ch_err[g].wake_nowu;
  end

  // Built from the registered sticky bits, so it trails them by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_any_q <= 1'b0;
    end else begin
      err_any_q <= |{err_timeout_o, err_drop_o, err_wake_nowu_o};
    end
  end

  assign err_any_o = err_any_q;

endmodule
`default_nettype wire

// File: tb/tb_uvma_wfe_wu_mc_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uvma_wfe_wu_mc_chk                                           |
// | Purpose  : Directed self-checking bench for uvma_wfe_wu_mc_chk. Three      |
// |            instances: A (2 ch, level), B (1 ch, pulse, shares A ch0        |
// |            inputs), C (1 ch, LAT_W=2, MAX_WU_LAT=3).                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uvma_wfe_wu_mc_chk;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b1;
  logic [1:0] cs_a = '0, wu_a = '0;
  logic cs_c = 1'b0, wu_c = 1'b0;

  logic [1:0]  to_a, dr_a, nw_a;
  logic [15:0] ll_a, wc_a;
  logic        any_a;
  logic [0:0]  to_b, dr_b, nw_b;
  logic [7:0]  ll_b, wc_b;
  logic        any_b;
  logic [0:0]  to_c, dr_c, nw_c;
  logic [1:0]  ll_c, wc_c;
  logic        any_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uvma_wfe_wu_mc_chk #(.NUM_CH(2), .MAX_WU_LAT(16), .LAT_W(8), .WU_LEVEL(1)) u_a (
    .clk(clk), .reset(reset), .core_sleep_i(cs_a), .wu_wfe_i(wu_a), .chk_en_i(chk_en),
    .err_timeout_o(to_a), .err_drop_o(dr_a), .err_wake_nowu_o(nw_a),
    .last_lat_o(ll_a), .wake_cnt_o(wc_a), .err_any_o(any_a));

  uvma_wfe_wu_mc_chk #(.NUM_CH(1), .MAX_WU_LAT(16), .LAT_W(8), .WU_LEVEL(0)) u_b (
    .clk(clk), .reset(reset), .core_sleep_i(cs_a[0]), .wu_wfe_i(wu_a[0]), .chk_en_i(chk_en),
    .err_timeout_o(to_b), .err_drop_o(dr_b), .err_wake_nowu_o(nw_b),
    .last_lat_o(ll_b), .wake_cnt_o(wc_b), .err_any_o(any_b));

  uvma_wfe_wu_mc_chk #(.NUM_CH(1), .MAX_WU_LAT(3), .LAT_W(2), .WU_LEVEL(1)) u_c (
    .clk(clk), .reset(reset), .core_sleep_i(cs_c), .wu_wfe_i(wu_c), .chk_en_i(chk_en),
    .err_timeout_o(to_c), .err_drop_o(dr_c), .err_wake_nowu_o(nw_c),
    .last_lat_o(ll_c), .wake_cnt_o(wc_c), .err_any_o(any_c));

  // Advance n active edges; inputs are changed and outputs sampled 1ns after.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    cs_a = '0; wu_a = '0; cs_c = 1'b0; wu_c = 1'b0; chk_en = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({to_a, dr_a, nw_a, ll_a, wc_a, any_a} !== 39'd0) begin
      n_err++; $display("FAIL reset_a: got %h want 0", {to_a, dr_a, nw_a, ll_a, wc_a, any_a});
    end
    n_cmp++;
    if ({to_b, dr_b, nw_b, ll_b, wc_b, any_b} !== 20'd0) begin
      n_err++; $display("FAIL reset_b: got %h want 0", {to_b, dr_b, nw_b, ll_b, wc_b, any_b});
    end
    n_cmp++;
    if ({to_c, dr_c, nw_c, ll_c, wc_c, any_c} !== 8'd0) begin
      n_err++; $display("FAIL reset_c: got %h want 0", {to_c, dr_c, nw_c, ll_c, wc_c, any_c});
    end
  endtask

  task automatic test_good_wake();
    do_reset();
    cs_a[0] = 1'b1;
    tick(3);               // into SLEEP, then two more sleeping cycles
    wu_a[0] = 1'b1;
    tick(4);               // accept + 3 pending cycles
    cs_a[0] = 1'b0;
    tick(1);               // wake 4 edges after acceptance
    wu_a[0] = 1'b0;
    n_cmp++;
    if (ll_a[7:0] !== 8'd4) begin
      n_err++; $display("FAIL good_lat: got %0d want 4", ll_a[7:0]);
    end
    n_cmp++;
    if (wc_a[7:0] !== 8'd1) begin
      n_err++; $display("FAIL good_cnt: got %0d want 1", wc_a[7:0]);
    end
    tick(1);
    n_cmp++;
    if ({to_a, dr_a, nw_a, any_a} !== 7'd0) begin
      n_err++; $display("FAIL good_noerr: got %b want 0", {to_a, dr_a, nw_a, any_a});
    end
    n_cmp++;
    if ({ll_a[15:8], wc_a[15:8]} !== 16'd0) begin
      n_err++; $display("FAIL good_ch1_idle: got %h want 0", {ll_a[15:8], wc_a[15:8]});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cs_a[0] = 1'b1; wu_a[0] = 1'b1;
    tick(1);               // AWAKE straight to WU_PEND
    tick(15);
    n_cmp++;
    if (to_a[0] !== 1'b0) begin
      n_err++; $display("FAIL to_early: got %b want 0", to_a[0]);
    end
    tick(1);               // 16th edge after acceptance
    n_cmp++;
    if (to_a[0] !== 1'b1 || any_a !== 1'b0) begin
      n_err++; $display("FAIL to_set: got to=%b any=%b want to=1 any=0", to_a[0], any_a);
    end
    tick(1);
    n_cmp++;
    if (any_a !== 1'b1) begin
      n_err++; $display("FAIL to_any: got %b want 1", any_a);
    end
    tick(2);
    n_cmp++;
    if (wc_a[7:0] !== 8'd0 || dr_a[0] !== 1'b0) begin
      n_err++; $display("FAIL to_cnt: got cnt=%0d drop=%b want 0/0", wc_a[7:0], dr_a[0]);
    end
  endtask

  task automatic test_drop();
    do_reset();
    cs_a[0] = 1'b1;
    tick(1);               // SLEEP
    wu_a[0] = 1'b1;
    tick(2);               // accept, one pending cycle with request held
    wu_a[0] = 1'b0;
    tick(1);               // request dropped while asleep
    n_cmp++;
    if (dr_a[0] !== 1'b1 || dr_b[0] !== 1'b0) begin
      n_err++; $display("FAIL drop_flag: got lvl=%b pulse=%b want 1/0", dr_a[0], dr_b[0]);
    end
    tick(4);
    cs_a[0] = 1'b0;
    tick(1);               // wake 7 edges after acceptance
    n_cmp++;
    if (ll_a[7:0] !== 8'd7 || wc_a[7:0] !== 8'd1) begin
      n_err++; $display("FAIL drop_lat_lvl: got lat=%0d cnt=%0d want 7/1", ll_a[7:0], wc_a[7:0]);
    end
    n_cmp++;
    if (ll_b !== 8'd7 || wc_b !== 8'd1 || dr_b[0] !== 1'b0) begin
      n_err++; $display("FAIL drop_pulse: got lat=%0d cnt=%0d drop=%b want 7/1/0", ll_b, wc_b, dr_b[0]);
    end
  endtask

  task automatic test_wake_nowu();
    do_reset();
    cs_a[0] = 1'b1;
    tick(10);
    cs_a[0] = 1'b0;
    tick(1);
    n_cmp++;
    if (nw_a[0] !== 1'b1 || wc_a[7:0] !== 8'd0) begin
      n_err++; $display("FAIL nowu_flag: got nowu=%b cnt=%0d want 1/0", nw_a[0], wc_a[7:0]);
    end
    cs_a[0] = 1'b1;
    tick(1);
    wu_a[0] = 1'b1;
    tick(1);
    cs_a[0] = 1'b0;
    tick(1);
    wu_a[0] = 1'b0;
    n_cmp++;
    if (wc_a[7:0] !== 8'd1 || ll_a[7:0] !== 8'd1 || nw_a[0] !== 1'b1 || any_a !== 1'b1) begin
      n_err++; $display("FAIL nowu_next: got cnt=%0d lat=%0d nowu=%b any=%b want 1/1/1/1",
                        wc_a[7:0], ll_a[7:0], nw_a[0], any_a);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cs_c = 1'b1;
      tick(1);             // SLEEP
      wu_c = 1'b1; cs_c = 1'b0;
      tick(1);             // request and wake on the same edge
      wu_c = 1'b0;
      n_cmp++;
      if (wc_c !== exp_cnt[k] || ll_c !== 2'd0) begin
        n_err++; $display("FAIL sat_%0d: got cnt=%0d lat=%0d want %0d/0", k, wc_c, ll_c, exp_cnt[k]);
      end
    end
    cs_c = 1'b1;
    tick(1);
    wu_c = 1'b1;
    tick(2);
    cs_c = 1'b0;
    tick(1);
    wu_c = 1'b0;
    n_cmp++;
    if (ll_c !== 2'd2 || wc_c !== 2'd3 || to_c[0] !== 1'b0) begin
      n_err++; $display("FAIL sat_lat: got lat=%0d cnt=%0d to=%b want 2/3/0", ll_c, wc_c, to_c[0]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cs_a[0] = 1'b1; wu_a[0] = 1'b1;
    tick(1);
    cs_a[0] = 1'b0;
    tick(1);               // good wake, wake_cnt = 1
    cs_a[0] = 1'b1;
    tick(3);               // pending again
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if ({to_a, dr_a, nw_a, ll_a, wc_a, any_a} !== 39'd0) begin
      n_err++; $display("FAIL midrst_out: got %h want 0", {to_a, dr_a, nw_a, ll_a, wc_a, any_a});
    end
    reset = 1'b0; cs_a[0] = 1'b0; wu_a[0] = 1'b0;
    tick(2);               // from AWAKE, an awake core records nothing
    n_cmp++;
    if (wc_a[7:0] !== 8'd0 || nw_a[0] !== 1'b0) begin
      n_err++; $display("FAIL midrst_state: got cnt=%0d nowu=%b want 0/0", wc_a[7:0], nw_a[0]);
    end
  endtask

  task automatic test_chk_en();
    do_reset();
    cs_a[0] = 1'b1; wu_a[0] = 1'b1;
    tick(5);               // accept + 4 pending cycles
    chk_en = 1'b0;
    cs_a[0] = 1'b0;        // must be ignored while disabled
    tick(30);
    cs_a[0] = 1'b1;
    n_cmp++;
    if (to_a[0] !== 1'b0 || wc_a[7:0] !== 8'd0) begin
      n_err++; $display("FAIL en_hold: got to=%b cnt=%0d want 0/0", to_a[0], wc_a[7:0]);
    end
    chk_en = 1'b1;
    tick(11);
    n_cmp++;
    if (to_a[0] !== 1'b0) begin
      n_err++; $display("FAIL en_resume_early: got %b want 0", to_a[0]);
    end
    tick(1);
    n_cmp++;
    if (to_a[0] !== 1'b1) begin
      n_err++; $display("FAIL en_resume_to: got %b want 1", to_a[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cs_a = 2'b11;
    tick(1);
    wu_a[0] = 1'b1; cs_a[1] = 1'b0;
    tick(1);               // ch0 accepts, ch1 wakes without request
    cs_a[0] = 1'b0;
    tick(1);
    wu_a[0] = 1'b0;
    n_cmp++;
    if (nw_a !== 2'b10 || to_a !== 2'b00 || dr_a !== 2'b00) begin
      n_err++; $display("FAIL b2b_err: got nowu=%b to=%b drop=%b want 10/00/00", nw_a, to_a, dr_a);
    end
    n_cmp++;
    if (wc_a !== 16'h0001 || ll_a !== 16'h0001) begin
      n_err++; $display("FAIL b2b_stat: got cnt=%h lat=%h want 0001/0001", wc_a, ll_a);
    end
  endtask

  initial begin
    test_reset();
    test_good_wake();
    test_timeout();
    test_drop();
    test_wake_nowu();
    test_saturate();
    test_mid_reset();
    test_chk_en();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
